// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module  : seg_pkg
// Purpose : Shared constants, FSM state type and nibble-select helper for the
//           seven-segment scan controller.
// Revision: 1.0 - initial release
// ============================================================================
package seg_pkg;

    localparam int NUM_DIGITS      = 4;
    localparam int DIG_W           = 2;
    localparam int NIB_W           = 4;
    localparam int DEF_REFRESH_DIV = 100000;
    localparam int DEF_BLANK_CYC   = 1000;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Digit 0 is the leftmost (most significant) nibble.
    function automatic logic [NIB_W-1:0] nib_sel(
        input logic [NUM_DIGITS*NIB_W-1:0] d,
        input logic [DIG_W-1:0]            k
    );
        logic [NIB_W-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (k == DIG_W'(i)) begin
                r = d[(NUM_DIGITS-1-i)*NIB_W +: NIB_W];
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_tick_gen.sv
`default_nettype none
// ============================================================================
// Module  : seg_tick_gen
// Purpose : Per-digit slot counter; flags the last cycle of a slot and whether
//           the upcoming cycle falls inside the anti-ghost blank window.
// Revision: 1.0 - initial release
// ============================================================================
module seg_tick_gen
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = DEF_REFRESH_DIV,
    parameter int BLANK_CYC   = DEF_BLANK_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic run_i,
    output logic slot_wrap_o,
    output logic blank_active_o
);

    localparam int c_CNT_W = $clog2(REFRESH_DIV);

    logic [c_CNT_W-1:0] cnt_q;
    logic [c_CNT_W-1:0] cnt_d;

    assign slot_wrap_o = run_i && (cnt_q == c_CNT_W'(REFRESH_DIV - 1));

    always_comb begin
        cnt_d = '0;
        if (run_i && !slot_wrap_o) begin
            cnt_d = cnt_q + c_CNT_W'(1);
        end
    end

    // Looks at the next count so the registered enable lines up with it.
    assign blank_active_o = (cnt_d < c_CNT_W'(BLANK_CYC));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : seg_scan_ctrl
// Purpose : Four-digit multiplexed display scanner with tear-free value update.
//           Define SEG_LZB_EN to enable leading-zero blanking.
// Revision: 1.0 - initial release
// ============================================================================
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = DEF_REFRESH_DIV,
    parameter int BLANK_CYC   = DEF_BLANK_CYC
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en_i,
    input  logic [NUM_DIGITS*NIB_W-1:0] value_i,
    input  logic                        load_i,
    output logic [NIB_W-1:0]            x_o,
    output logic [DIG_W-1:0]            dig_o,
    output logic                        seg_en_o,
    output logic                        pending_o,
    output logic                        load_ack_o
);

    localparam logic [DIG_W-1:0] c_LAST_DIG = DIG_W'(NUM_DIGITS - 1);

    state_t                      state_q, state_d;
    logic [DIG_W-1:0]            dig_q, dig_d;
    logic [NUM_DIGITS*NIB_W-1:0] disp_q, disp_d;
    logic [NUM_DIGITS*NIB_W-1:0] shadow_q, shadow_d;
    logic                        pending_q, pending_d;
    logic                        load_ack_q, load_ack_d;
    logic [NIB_W-1:0]            x_q, x_d;
    logic                        seg_en_q, seg_en_d;

    logic run;
    logic slot_wrap;
    logic blank_active;
    logic apply;

    assign run = (state_q == SCAN) && en_i;

    seg_tick_gen #(
        .REFRESH_DIV (REFRESH_DIV),
        .BLANK_CYC   (BLANK_CYC)
    ) u_tick (
        .clk            (clk),
        .rst            (rst),
        .run_i          (run),
        .slot_wrap_o    (slot_wrap),
        .blank_active_o (blank_active)
    );

    always_comb begin
        state_d    = en_i ? SCAN : IDLE;
        dig_d      = '0;
        disp_d     = disp_q;
        shadow_d   = shadow_q;
        pending_d  = pending_q;
        load_ack_d = 1'b0;

        if (run) begin
            dig_d = slot_wrap ? dig_q + DIG_W'(1) : dig_q;
        end

        // Holding off while load_ack is high keeps the ack a single pulse
        // when a new capture lands on the apply cycle.
        apply = pending_q && !load_ack_q &&
                ((state_q == IDLE) || (slot_wrap && (dig_q == c_LAST_DIG)));

        if (apply) begin
            disp_d     = shadow_q;
            pending_d  = 1'b0;
            load_ack_d = 1'b1;
        end
        if (load_i) begin
            shadow_d  = value_i;
            pending_d = 1'b1;
        end

        x_d = nib_sel(disp_d, dig_d);
    end

`ifdef SEG_LZB_EN
    logic lzb_blank;

    always_comb begin
        lzb_blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS - 1; i++) begin
            if (dig_d == DIG_W'(i)) begin
                lzb_blank = ((disp_d >> ((NUM_DIGITS - 1 - i) * NIB_W)) == '0);
            end
        end
    end

    assign seg_en_d = (state_d == SCAN) && !blank_active && !lzb_blank;
`else
    assign seg_en_d = (state_d == SCAN) && !blank_active;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            dig_q      <= '0;
            disp_q     <= '0;
            shadow_q   <= '0;
            pending_q  <= 1'b0;
            load_ack_q <= 1'b0;
            x_q        <= '0;
            seg_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            dig_q      <= dig_d;
            disp_q     <= disp_d;
            shadow_q   <= shadow_d;
            pending_q  <= pending_d;
            load_ack_q <= load_ack_d;
            x_q        <= x_d;
            seg_en_q   <= seg_en_d;
        end
    end

    assign x_o        = x_q;
    assign dig_o      = dig_q;
    assign seg_en_o   = seg_en_q;
    assign pending_o  = pending_q;
    assign load_ack_o = load_ack_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_seg_scan_ctrl
// Purpose : Self-checking bench for seg_scan_ctrl (REFRESH_DIV=8, BLANK_CYC=2).
// Revision: 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;

    localparam int P = 8;
    localparam int B = 2;
`ifdef SEG_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    typedef struct packed {
        logic        en;
        logic        ld;
        logic [15:0] v;
        logic [8:0]  ex;
    } item_t;

    logic        clk;
    logic        rst;
    logic        en;
    logic        load;
    logic [15:0] value;
    logic [3:0]  x_o;
    logic [1:0]  dig_o;
    logic        seg_en_o;
    logic        pending_o;
    logic        load_ack_o;
    logic [8:0]  obs;

    item_t sb[$];
    int    checks;
    int    errors;
    int    m_dig;
    int    m_cnt;

    seg_scan_ctrl #(
        .REFRESH_DIV (P),
        .BLANK_CYC   (B)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en_i       (en),
        .value_i    (value),
        .load_i     (load),
        .x_o        (x_o),
        .dig_o      (dig_o),
        .seg_en_o   (seg_en_o),
        .pending_o  (pending_o),
        .load_ack_o (load_ack_o)
    );

    assign obs = {dig_o, x_o, seg_en_o, pending_o, load_ack_o};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] mk(input int d, input logic [3:0] xx,
                                      input logic s, input logic p, input logic a);
        return {2'(d), xx, s, p, a};
    endfunction

    function automatic logic [3:0] nib(input logic [15:0] d, input int k);
        return d[4*(3-k) +: 4];
    endfunction

    function automatic logic exp_seg(input int cnt, input logic [15:0] d, input int dig);
        logic s;
        s = (cnt >= B);
        if (LZB && dig < 3 && ((d >> (4*(3-dig))) == 16'h0)) s = 1'b0;
        return s;
    endfunction

    task automatic push(input logic e, input logic l, input logic [15:0] v, input logic [8:0] ex);
        item_t it;
        it = '{en: e, ld: l, v: v, ex: ex};
        sb.push_back(it);
    endtask

    // Queue n scanning cycles; position tracked by the bench's own slot counter.
    task automatic push_scan(input int n, input logic [15:0] d, input logic pend,
                             input logic ack, input logic ld, input logic [15:0] v);
        for (int i = 0; i < n; i++) begin
            if (m_cnt == P - 1) begin
                m_cnt = 0;
                m_dig = (m_dig + 1) % 4;
            end else begin
                m_cnt++;
            end
            push(1'b1, ld, v, mk(m_dig, nib(d, m_dig), exp_seg(m_cnt, d, m_dig), pend, ack));
        end
    endtask

    task automatic scan_from_idle();
        m_dig = 3;
        m_cnt = P - 1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; load = 1'b0; value = 16'h0;
        @(posedge clk); #1;
        checks++;
        if (obs !== 9'h0) begin
            errors++;
            $display("FAIL reset_state got %h want 000", obs);
        end
        checks++;
        if (x_o !== 4'h0 || dig_o !== 2'd0) begin
            errors++;
            $display("FAIL reset_xdig got x=%h dig=%0d want x=0 dig=0", x_o, dig_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_idle_load();
        item_t it;
        push(0, 1, 16'hAAAA, mk(0, 4'h0, 0, 1, 0));
        push(0, 1, 16'hBBBB, mk(0, 4'hA, 0, 1, 1));
        push(0, 0, 16'h0,    mk(0, 4'hA, 0, 1, 0));
        push(0, 0, 16'h0,    mk(0, 4'hB, 0, 0, 1));
        push(0, 1, 16'h1234, mk(0, 4'hB, 0, 1, 0));
        push(0, 0, 16'h0,    mk(0, 4'h1, 0, 0, 1));
        push(0, 0, 16'h0,    mk(0, 4'h1, 0, 0, 0));
        for (int n = 0; sb.size() != 0; n++) begin
            it = sb.pop_front();
            en = it.en; load = it.ld; value = it.v;
            @(posedge clk); #1;
            checks++;
            if (obs !== it.ex) begin
                errors++;
                $display("FAIL idle_load item %0d got %h want %h", n, obs, it.ex);
            end
        end
    endtask

    task automatic test_scan();
        item_t it;
        scan_from_idle();
        push_scan(5*P, 16'h1234, 0, 0, 0, 16'h0);
        for (int n = 0; sb.size() != 0; n++) begin
            it = sb.pop_front();
            en = it.en; load = it.ld; value = it.v;
            @(posedge clk); #1;
            checks++;
            if (obs !== it.ex) begin
                errors++;
                $display("FAIL scan item %0d got dig=%0d x=%h seg_en=%b want dig=%0d x=%h seg_en=%b",
                         n, obs[8:7], obs[6:3], obs[2], it.ex[8:7], it.ex[6:3], it.ex[2]);
            end
        end
    endtask

    task automatic test_load_boundary();
        item_t it;
        push_scan(4, 16'h1234, 0, 0, 0, 16'h0);
        push_scan(1, 16'h1234, 1, 0, 1, 16'hABCD);
        push_scan(19, 16'h1234, 1, 0, 0, 16'h0);
        push_scan(1, 16'hABCD, 0, 1, 0, 16'h0);
        push_scan(4*P - 1, 16'hABCD, 0, 0, 0, 16'h0);
        for (int n = 0; sb.size() != 0; n++) begin
            it = sb.pop_front();
            en = it.en; load = it.ld; value = it.v;
            @(posedge clk); #1;
            checks++;
            if (obs !== it.ex) begin
                errors++;
                $display("FAIL load_boundary item %0d got %h want %h", n, obs, it.ex);
            end
        end
    endtask

    task automatic test_latest_wins();
        item_t it;
        push_scan(2, 16'hABCD, 0, 0, 0, 16'h0);
        push_scan(1, 16'hABCD, 1, 0, 1, 16'h1111);
        push_scan(5, 16'hABCD, 1, 0, 0, 16'h0);
        push_scan(1, 16'hABCD, 1, 0, 1, 16'h2222);
        push_scan(23, 16'hABCD, 1, 0, 0, 16'h0);
        push_scan(1, 16'h2222, 0, 1, 0, 16'h0);
        push_scan(4*P - 1, 16'h2222, 0, 0, 0, 16'h0);
        for (int n = 0; sb.size() != 0; n++) begin
            it = sb.pop_front();
            en = it.en; load = it.ld; value = it.v;
            @(posedge clk); #1;
            checks++;
            if (obs !== it.ex) begin
                errors++;
                $display("FAIL latest_wins item %0d got %h want %h", n, obs, it.ex);
            end
        end
    endtask

    task automatic test_en_drop();
        item_t it;
        push_scan(22, 16'h2222, 0, 0, 0, 16'h0);
        push(0, 0, 16'h0, mk(0, 4'h2, 0, 0, 0));
        push(0, 0, 16'h0, mk(0, 4'h2, 0, 0, 0));
        scan_from_idle();
        push_scan(10, 16'h2222, 0, 0, 0, 16'h0);
        for (int n = 0; sb.size() != 0; n++) begin
            it = sb.pop_front();
            en = it.en; load = it.ld; value = it.v;
            @(posedge clk); #1;
            checks++;
            if (obs !== it.ex) begin
                errors++;
                $display("FAIL en_drop item %0d got %h want %h", n, obs, it.ex);
            end
        end
    endtask

    task automatic test_reset_pending();
        item_t it;
        push_scan(1, 16'h2222, 1, 0, 1, 16'h5A5A);
        it = sb.pop_front();
        en = it.en; load = it.ld; value = it.v;
        @(posedge clk); #1;
        checks++;
        if (obs !== it.ex) begin
            errors++;
            $display("FAIL reset_pending_arm got %h want %h", obs, it.ex);
        end
        load = 1'b0; en = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (obs !== 9'h0) begin
            errors++;
            $display("FAIL async_reset got %h want 000", obs);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        push(0, 0, 16'h0, mk(0, 4'h0, 0, 0, 0));
        push(0, 0, 16'h0, mk(0, 4'h0, 0, 0, 0));
        scan_from_idle();
        push_scan(4*P, 16'h0000, 0, 0, 0, 16'h0);
        for (int n = 0; sb.size() != 0; n++) begin
            it = sb.pop_front();
            en = it.en; load = it.ld; value = it.v;
            @(posedge clk); #1;
            checks++;
            if (obs !== it.ex) begin
                errors++;
                $display("FAIL after_reset item %0d got %h want %h", n, obs, it.ex);
            end
        end
    endtask

    task automatic test_sparse_value();
        item_t it;
        push(0, 0, 16'h0,    mk(0, 4'h0, 0, 0, 0));
        push(0, 1, 16'h0070, mk(0, 4'h0, 0, 1, 0));
        push(0, 0, 16'h0,    mk(0, 4'h0, 0, 0, 1));
        scan_from_idle();
        push_scan(4*P, 16'h0070, 0, 0, 0, 16'h0);
        for (int n = 0; sb.size() != 0; n++) begin
            it = sb.pop_front();
            en = it.en; load = it.ld; value = it.v;
            @(posedge clk); #1;
            checks++;
            if (obs !== it.ex) begin
                errors++;
                $display("FAIL sparse_value item %0d got %h want %h", n, obs, it.ex);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_dig  = 0;
        m_cnt  = 0;
        test_reset();
        test_idle_load();
        test_scan();
        test_load_boundary();
        test_latest_wins();
        test_en_drop();
        test_reset_pending();
        test_sparse_value();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired after %0d checks", checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
